imm_gen_pipe: RTL and testbench

- Parametrised, buffered successor to the combinational immediate generator.
- Decodes every RV32I/RV64I immediate format: I, S, B, U and J, plus the CSR zero-extended immediate.
- Sign-extends to XLEN and reports the decoded format and an illegal-opcode flag.
- Sits between instruction fetch/IR and the operand-select logic; results queue in a small output FIFO behind a valid/ready handshake so decode decouples from datapath stalls.

---
 rtl/imm_gen_pipe_if.sv | 28 ++
 rtl/imm_gen_pipe.sv | 191 +++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the immediate generator and its producer/consumer.
// slave: the generator side; master: the fetch/operand-select side.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            iValid;
    logic            oReady;
    logic [31:0]     iInstrucao;
    logic            oValid;
    logic            iReady;
    logic [XLEN-1:0] oImm;
    logic [2:0]      oFmt;
    logic            oIllegal;
    logic [CW-1:0]   oCount;

    modport slave (
        input  iValid, iInstrucao, iReady,
        output oReady, oValid, oImm, oFmt, oIllegal, oCount
    );

    modport master (
        output iValid, iInstrucao, iReady,
        input  oReady, oValid, oImm, oFmt, oIllegal, oCount
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate decoder feeding a small valid/ready output FIFO.
// Each entry carries the sign-extended immediate, its format code and an illegal flag.
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter bit ENABLE_CSR = 1'b1
) (
    input  logic          iCLK,
    input  logic          iRST,
    imm_gen_pipe_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    // Every immediate is first assembled as 32 bits, then widened from bit 31.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    entry_t          dec_s;
    entry_t          head_s;
    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_s, pop_s, empty_s;
    logic [31:0]     ins_s;

    assign ins_s = bus.iInstrucao;

    // Instruction decode into a FIFO entry.
    always_comb begin
        dec_s.imm     = '0;
        dec_s.fmt     = FMT_NONE;
        dec_s.illegal = 1'b0;
        if (ins_s[1:0] != 2'b11) begin
            dec_s.illegal = 1'b1;
        end else begin
            case (ins_s[6:0])
                OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                    dec_s.fmt = FMT_I;
                    dec_s.imm = sext32({{20{ins_s[31]}}, ins_s[31:20]});
                end
                OPC_OP_IMM32: begin
                    if (XLEN == 64) begin
                        dec_s.fmt = FMT_I;
                        dec_s.imm = sext32({{20{ins_s[31]}}, ins_s[31:20]});
                    end else begin
                        dec_s.illegal = 1'b1;
                    end
                end
                OPC_STORE: begin
                    dec_s.fmt = FMT_S;
                    dec_s.imm = sext32({{20{ins_s[31]}}, ins_s[31:25], ins_s[11:7]});
                end
                OPC_BRANCH: begin
                    dec_s.fmt = FMT_B;
                    dec_s.imm = sext32({{19{ins_s[31]}}, ins_s[31], ins_s[7],
                                        ins_s[30:25], ins_s[11:8], 1'b0});
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec_s.fmt = FMT_U;
                    dec_s.imm = sext32({ins_s[31:12], 12'b0});
                end
                OPC_JAL: begin
                    dec_s.fmt = FMT_J;
                    dec_s.imm = sext32({{11{ins_s[31]}}, ins_s[31], ins_s[19:12],
                                        ins_s[20], ins_s[30:21], 1'b0});
                end
                OPC_SYSTEM: begin
                    if (ENABLE_CSR && ins_s[14]) begin
                        dec_s.fmt      = FMT_Z;
                        dec_s.imm[4:0] = ins_s[19:15];
                    end else begin
                        dec_s.fmt = FMT_NONE;
                    end
                end
                OPC_OP, OPC_FENCE: begin
                    dec_s.fmt = FMT_NONE;
                end
                OPC_OP32: begin
                    if (XLEN == 64) begin
                        dec_s.fmt = FMT_NONE;
                    end else begin
                        dec_s.illegal = 1'b1;
                    end
                end
                default: begin
                    dec_s.illegal = 1'b1;
                end
            endcase
        end
    end

    assign empty_s    = (count_q == '0);
    assign bus.oReady = ~iRST & (count_q != FULL_C);
    assign bus.oValid = ~empty_s;
    assign push_s     = bus.iValid & bus.oReady;
    assign pop_s      = ~empty_s & bus.iReady;

    // Head presentation; an empty FIFO drives all-zero payload.
    always_comb begin
        head_s = '0;
        if (!empty_s) begin
            head_s = mem_q[rd_ptr_q];
        end else begin
            head_s = '0;
        end
    end

    assign bus.oImm     = head_s.imm;
    assign bus.oFmt     = head_s.fmt;
    assign bus.oIllegal = head_s.illegal;
    assign bus.oCount   = count_q;

    // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observable through a non-zero count.
    always_ff @(posedge iCLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= dec_s;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances cover XLEN=32 with and without
// the CSR format and XLEN=64, all DEPTH=2.
module tb_imm_gen_pipe;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    imm_gen_pipe_if #(.XLEN(32), .DEPTH(2)) ifa ();
    imm_gen_pipe_if #(.XLEN(32), .DEPTH(2)) ifc ();
    imm_gen_pipe_if #(.XLEN(64), .DEPTH(2)) ifd ();

    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .ENABLE_CSR(1'b1)) u_a (.iCLK(clk), .iRST(rst), .bus(ifa.slave));
    imm_gen_pipe #(.XLEN(32), .DEPTH(2), .ENABLE_CSR(1'b0)) u_c (.iCLK(clk), .iRST(rst), .bus(ifc.slave));
    imm_gen_pipe #(.XLEN(64), .DEPTH(2), .ENABLE_CSR(1'b1)) u_d (.iCLK(clk), .iRST(rst), .bus(ifd.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic head_a(input string tag, input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
        check_eq({tag, "_valid"}, 64'(ifa.oValid), 64'h1);
        check_eq({tag, "_imm"},   64'(ifa.oImm),   64'(imm));
        check_eq({tag, "_fmt"},   64'(ifa.oFmt),   64'(fmt));
        check_eq({tag, "_ill"},   64'(ifa.oIllegal), 64'(ill));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        ifa.iValid = 1'b0; ifa.iReady = 1'b1; ifa.iInstrucao = 32'h0;
        ifc.iValid = 1'b0; ifc.iReady = 1'b1; ifc.iInstrucao = 32'h0;
        ifd.iValid = 1'b0; ifd.iReady = 1'b1; ifd.iInstrucao = 32'h0;

        // Reset
        rst = 1'b1;
        step();
        step();
        check_eq("rst_ready_low", 64'(ifa.oReady), 64'h0);
        check_eq("rst_valid",     64'(ifa.oValid), 64'h0);
        check_eq("rst_count",     64'(ifa.oCount), 64'h0);
        check_eq("rst_imm",       64'(ifa.oImm),   64'h0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 64'(ifa.oReady), 64'h1);

        // 1: addi x1,x0,-1 with one-cycle latency, no bypass
        ifa.iInstrucao = 32'hFFF00093;
        ifa.iValid     = 1'b1;
        #1;
        check_eq("no_bypass", 64'(ifa.oValid), 64'h0);
        step();
        ifa.iValid = 1'b0;
        head_a("addi", 32'hFFFFFFFF, 3'd1, 1'b0);
        check_eq("addi_count", 64'(ifa.oCount), 64'h1);
        step();
        check_eq("addi_popped", 64'(ifa.oValid), 64'h0);
        check_eq("empty_imm",   64'(ifa.oImm),   64'h0);

        // 2: back-to-back S/B/U/J with simultaneous push and pop
        ifa.iValid = 1'b1;
        ifa.iInstrucao = 32'hFE512E23; step();
        head_a("sw", 32'hFFFFFFFC, 3'd2, 1'b0);
        ifa.iInstrucao = 32'hFE000EE3; step();
        head_a("beq", 32'hFFFFFFFC, 3'd3, 1'b0);
        check_eq("b2b_count", 64'(ifa.oCount), 64'h1);
        ifa.iInstrucao = 32'h123450B7; step();
        head_a("lui", 32'h12345000, 3'd4, 1'b0);
        ifa.iInstrucao = 32'h001000EF; step();
        head_a("jal", 32'h00000800, 3'd5, 1'b0);
        ifa.iValid = 1'b0;
        step();
        check_eq("b2b_drained", 64'(ifa.oCount), 64'h0);

        // 3: backpressure with DEPTH=2
        ifa.iReady = 1'b0;
        ifa.iValid = 1'b1;
        ifa.iInstrucao = 32'h00100093; step();
        check_eq("bp_count1", 64'(ifa.oCount), 64'h1);
        check_eq("bp_ready1", 64'(ifa.oReady), 64'h1);
        ifa.iInstrucao = 32'h00200093; step();
        check_eq("bp_count2", 64'(ifa.oCount), 64'h2);
        check_eq("bp_full_ready", 64'(ifa.oReady), 64'h0);
        ifa.iInstrucao = 32'h00300093; step();
        check_eq("bp_held_count", 64'(ifa.oCount), 64'h2);
        head_a("bp_h1", 32'h00000001, 3'd1, 1'b0);
        ifa.iReady = 1'b1;
        step();
        check_eq("bp_pop_count", 64'(ifa.oCount), 64'h1);
        head_a("bp_h2", 32'h00000002, 3'd1, 1'b0);
        step();
        ifa.iValid = 1'b0;
        head_a("bp_h3", 32'h00000003, 3'd1, 1'b0);
        check_eq("bp_h3_count", 64'(ifa.oCount), 64'h1);
        step();
        check_eq("bp_empty", 64'(ifa.oValid), 64'h0);

        // 4: csrrwi with and without the Z format
        ifa.iInstrucao = 32'h000FD073; ifa.iValid = 1'b1; ifa.iReady = 1'b0;
        ifc.iInstrucao = 32'h000FD073; ifc.iValid = 1'b1; ifc.iReady = 1'b0;
        step();
        ifa.iValid = 1'b0; ifc.iValid = 1'b0;
        head_a("csr", 32'h0000001F, 3'd6, 1'b0);
        check_eq("nocsr_valid", 64'(ifc.oValid),   64'h1);
        check_eq("nocsr_imm",   64'(ifc.oImm),     64'h0);
        check_eq("nocsr_fmt",   64'(ifc.oFmt),     64'h0);
        check_eq("nocsr_ill",   64'(ifc.oIllegal), 64'h0);
        ifa.iReady = 1'b1; ifc.iReady = 1'b1;
        step();

        // 5: all-zero word is illegal; OP_IMM_32 illegal on XLEN=32
        ifa.iInstrucao = 32'h00000000; ifa.iValid = 1'b1;
        step();
        head_a("zero", 32'h0, 3'd0, 1'b1);
        ifa.iInstrucao = 32'hFFF0009B;
        step();
        ifa.iValid = 1'b0;
        head_a("addiw32", 32'h0, 3'd0, 1'b1);
        step();

        // 6: XLEN=64 sign extension, then reset with a full FIFO
        ifd.iReady = 1'b0;
        ifd.iValid = 1'b1;
        ifd.iInstrucao = 32'hFFF0009B; step();
        check_eq("addiw_imm", ifd.oImm, 64'hFFFFFFFFFFFFFFFF);
        check_eq("addiw_fmt", 64'(ifd.oFmt), 64'h1);
        ifd.iInstrucao = 32'h800000B7; step();
        ifd.iValid = 1'b0;
        check_eq("x64_full_count", 64'(ifd.oCount), 64'h2);
        check_eq("x64_full_ready", 64'(ifd.oReady), 64'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("x64_rst_valid", 64'(ifd.oValid), 64'h0);
        check_eq("x64_rst_count", 64'(ifd.oCount), 64'h0);
        check_eq("x64_rst_imm",   ifd.oImm,        64'h0);
        ifd.iValid = 1'b1;
        ifd.iInstrucao = 32'h800000B7; step();
        ifd.iValid = 1'b0;
        check_eq("x64_lui_imm",   ifd.oImm,        64'hFFFFFFFF80000000);
        check_eq("x64_lui_count", 64'(ifd.oCount), 64'h1);
        ifd.iReady = 1'b1;
        step();
        check_eq("x64_no_stale", 64'(ifd.oValid), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
